// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared pipeline-control definitions for the ID-stage hazard logic.
//   hz_state_t    : load-use stall sequencer states (2-bit, 2'b11 unused)
//   MEMREAD_NONE  : MemRead code of an instruction that is not a load
//   REG_ZERO      : architectural register 0, hard-wired to zero
// ---------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        LD_WAIT = 2'b01,
        LD_FWD  = 2'b10
    } hz_state_t;

    localparam logic [1:0] MEMREAD_NONE = 2'b00;
    localparam logic [4:0] REG_ZERO     = 5'd0;

endpackage : pipe_pkg

// File: rtl/hazard_cmp.sv
// ---------------------------------------------------------------------------
// hazard_cmp
// Purely combinational check of whether a consumer instruction reads a
// register that a load further down the pipe is about to write.
// Ports:
//   rs, rt         in  5  consumer source registers
//   use_rs, use_rt in  1  consumer actually reads rs / rt
//   rd             in  5  producer destination register
//   regwrite       in  1  producer writes the register file
//   memread        in  2  producer MemRead code; nonzero = load
//   hz             out 1  1 = consumer depends on the in-flight load
// ---------------------------------------------------------------------------
module hazard_cmp
    import pipe_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       use_rs,
    input  logic       use_rt,
    input  logic [4:0] rd,
    input  logic       regwrite,
    input  logic [1:0] memread,
    output logic       hz
);

    logic producer_is_load;
    logic rs_match;
    logic rt_match;

    // Register 0 is never really written, so it can never be pending.
    assign producer_is_load = regwrite && (memread != MEMREAD_NONE) && (rd != REG_ZERO);
    assign rs_match         = use_rs && (rs == rd);
    assign rt_match         = use_rt && (rt == rd);
    assign hz               = producer_is_load && (rs_match || rt_match);

endmodule : hazard_cmp

// File: rtl/load_use_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// load_use_hazard_ctrl
// Detects a load in EXE feeding the instruction in ID, stalls ID for one
// cycle, then tells ID to take the load data from MEM. Also flushes IF/ID
// on a taken branch/jump when no stall is in progress.
//
// Handshake with id: while id_lw_exe=1 the load result is not yet available
// and id must leave out1/out2 untouched; in the following cycle id_lw=1 and
// id substitutes Rdata_mem for every operand that matched the load.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   hold                external freeze: state/counter hold, PC/IF-ID held
//   id_rs/id_rt         ID source registers, id_use_rs/id_use_rt = read
//   exe_rd/exe_regwrite/exe_memread  EXE destination and load status
//   br_taken            branch/jump resolved taken in ID
//   keep                hold PC and IF/ID
//   bubble_ex           insert NOP into ID/EXE
//   flush_ifid          replace IF/ID with NOP
//   id_lw_exe           load in EXE feeds ID (id must not update operands)
//   id_lw               stalled load now in MEM (id takes Rdata_mem)
//   stall_cnt           saturating count of stall cycles since reset
//   dbg_state           current sequencer state (hz_state_t encoding)
// ---------------------------------------------------------------------------
module load_use_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [4:0]       exe_rd,
    input  logic             exe_regwrite,
    input  logic [1:0]       exe_memread,
    input  logic             br_taken,
    output logic             keep,
    output logic             bubble_ex,
    output logic             flush_ifid,
    output logic             id_lw_exe,
    output logic             id_lw,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       dbg_state
);

    hz_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lw_exe_q, lw_exe_d;

    logic hz;
    logic stall;       // RUN-like state with a live hazard: this is a lost cycle
    logic id_lw_raw;

    hazard_cmp u_hazard_cmp (
        .rs       (id_rs),
        .rt       (id_rt),
        .use_rs   (id_use_rs),
        .use_rt   (id_use_rt),
        .rd       (exe_rd),
        .regwrite (exe_regwrite),
        .memread  (exe_memread),
        .hz       (hz)
    );

    // Next-state and raw (pre-hold, pre-reset) decode.
    always_comb begin
        stall     = 1'b0;
        id_lw_raw = 1'b0;
        state_d   = state_q;
        case (state_q)
            // LD_FWD normally cannot see a hazard (EXE holds the bubble); if
            // one shows up anyway it is handled exactly like RUN.
            RUN, LD_FWD: begin
                stall   = hz;
                state_d = hz ? LD_WAIT : RUN;
            end
            LD_WAIT: begin
                id_lw_raw = 1'b1;
                state_d   = LD_FWD;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (hold) begin
            state_d = state_q;
        end
    end

    // id_lw_exe must stay at its pre-freeze value for the whole hold window,
    // so the last unfrozen value is remembered here.
    always_comb begin
        lw_exe_d = hold ? lw_exe_q : stall;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!hold && stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            lw_exe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lw_exe_q <= lw_exe_d;
        end
    end

    // Outputs are gated by reset so a stall seen during reset never leaks out.
    assign keep       = reset && (hold || stall);
    assign bubble_ex  = reset && !hold && stall;
    assign flush_ifid = reset && !hold && br_taken && !stall;
    assign id_lw      = reset && !hold && id_lw_raw;
    assign id_lw_exe  = reset && (hold ? lw_exe_q : stall);
    assign stall_cnt  = cnt_q;
    assign dbg_state  = state_q;

endmodule : load_use_hazard_ctrl

// File: tb/tb_load_use_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_load_use_hazard_ctrl
// Directed bench for load_use_hazard_ctrl. Two instances share all inputs:
// the default 32-bit counter version and a CNT_W=4 version for saturation.
// Inputs change 1ns after the rising edge; outputs are sampled 2ns after it.
// ---------------------------------------------------------------------------
module tb_load_use_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic       hold;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic [4:0] exe_rd;
    logic       exe_regwrite;
    logic [1:0] exe_memread;
    logic       br_taken;

    logic        keep, bubble_ex, flush_ifid, id_lw_exe, id_lw;
    logic [31:0] stall_cnt;
    logic [1:0]  dbg_state;

    logic        keep4, bubble_ex4, flush_ifid4, id_lw_exe4, id_lw4;
    logic [3:0]  stall_cnt4;
    logic [1:0]  dbg_state4;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    localparam logic [1:0] S_RUN     = 2'b00;
    localparam logic [1:0] S_LD_WAIT = 2'b01;
    localparam logic [1:0] S_LD_FWD  = 2'b10;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    load_use_hazard_ctrl u_dut (
        .clk          (clk),
        .reset        (reset),
        .hold         (hold),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .exe_rd       (exe_rd),
        .exe_regwrite (exe_regwrite),
        .exe_memread  (exe_memread),
        .br_taken     (br_taken),
        .keep         (keep),
        .bubble_ex    (bubble_ex),
        .flush_ifid   (flush_ifid),
        .id_lw_exe    (id_lw_exe),
        .id_lw        (id_lw),
        .stall_cnt    (stall_cnt),
        .dbg_state    (dbg_state)
    );

    load_use_hazard_ctrl #(.CNT_W(4)) u_dut4 (
        .clk          (clk),
        .reset        (reset),
        .hold         (hold),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .exe_rd       (exe_rd),
        .exe_regwrite (exe_regwrite),
        .exe_memread  (exe_memread),
        .br_taken     (br_taken),
        .keep         (keep4),
        .bubble_ex    (bubble_ex4),
        .flush_ifid   (flush_ifid4),
        .id_lw_exe    (id_lw_exe4),
        .id_lw        (id_lw4),
        .stall_cnt    (stall_cnt4),
        .dbg_state    (dbg_state4)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_exe(input logic [4:0] rd, input logic rw, input logic [1:0] mr);
        exe_rd       = rd;
        exe_regwrite = rw;
        exe_memread  = mr;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic urs,
                          input logic [4:0] rt, input logic urt);
        id_rs     = rs;
        id_use_rs = urs;
        id_rt     = rt;
        id_use_rt = urt;
    endtask

    task automatic exe_bubble();
        set_exe(5'd0, 1'b0, 2'b00);
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic k, input logic b,
                              input logic f, input logic le, input logic l);
        check({tag, ".keep"},       32'(keep),       32'(k));
        check({tag, ".bubble_ex"},  32'(bubble_ex),  32'(b));
        check({tag, ".flush_ifid"}, 32'(flush_ifid), 32'(f));
        check({tag, ".id_lw_exe"},  32'(id_lw_exe),  32'(le));
        check({tag, ".id_lw"},      32'(id_lw),      32'(l));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b0;
        hold  = 1'b0;
        br_taken = 1'b0;
        set_id(5'd0, 1'b0, 5'd0, 1'b0);
        exe_bubble();

        // Reset state
        #2;
        check_outs("rst", 0, 0, 0, 0, 0);
        check("rst.cnt", stall_cnt, 32'd0);
        check("rst.state", 32'(dbg_state), 32'(S_RUN));
        tick();
        reset = 1'b1;
        tick();

        // lw r1 in EXE, ID add r2,r1,r3
        set_exe(5'd1, 1'b1, 2'b01);
        set_id(5'd1, 1'b1, 5'd3, 1'b1);
        settle();
        check_outs("lu.c0", 1, 1, 0, 1, 0);
        check("lu.c0.state", 32'(dbg_state), 32'(S_RUN));
        tick();
        exe_bubble();
        settle();
        check_outs("lu.c1", 0, 0, 0, 0, 1);
        check("lu.c1.state", 32'(dbg_state), 32'(S_LD_WAIT));
        check("lu.c1.cnt", stall_cnt, 32'd1);
        tick();
        set_exe(5'd2, 1'b1, 2'b00);              // add r2 now in EXE
        set_id(5'd4, 1'b1, 5'd6, 1'b1);
        settle();
        check_outs("lu.c2", 0, 0, 0, 0, 0);
        check("lu.c2.state", 32'(dbg_state), 32'(S_LD_FWD));
        check("lu.c2.cnt", stall_cnt, 32'd1);
        tick();
        settle();
        check("lu.c3.state", 32'(dbg_state), 32'(S_RUN));

        // No-hazard patterns
        set_exe(5'd0, 1'b1, 2'b01);              // lw r0
        set_id(5'd0, 1'b1, 5'd0, 1'b1);
        settle();
        check_outs("r0", 0, 0, 0, 0, 0);
        tick();
        set_exe(5'd5, 1'b1, 2'b00);              // add writing r5
        set_id(5'd5, 1'b1, 5'd5, 1'b1);
        settle();
        check_outs("alu", 0, 0, 0, 0, 0);
        tick();
        set_exe(5'd5, 1'b1, 2'b10);              // lw r5, ID does not read it
        set_id(5'd5, 1'b0, 5'd5, 1'b0);
        settle();
        check_outs("nouse", 0, 0, 0, 0, 0);
        tick();
        set_exe(5'd5, 1'b0, 2'b01);              // load with regwrite=0
        set_id(5'd5, 1'b1, 5'd0, 1'b0);
        settle();
        check_outs("norw", 0, 0, 0, 0, 0);
        check("norw.cnt", stall_cnt, 32'd1);
        tick();

        // Branch during stall is suppressed; taken next cycle flushes
        set_exe(5'd7, 1'b1, 2'b11);
        set_id(5'd2, 1'b0, 5'd7, 1'b1);          // rt-only match
        br_taken = 1'b1;
        settle();
        check_outs("br.stall", 1, 1, 0, 1, 0);
        tick();
        exe_bubble();
        settle();
        check_outs("br.next", 0, 0, 1, 0, 1);
        tick();
        br_taken = 1'b0;
        set_id(5'd0, 1'b0, 5'd0, 1'b0);
        settle();
        check_outs("br.fwd", 0, 0, 0, 0, 0);
        check("br.cnt", stall_cnt, 32'd2);
        tick();

        // Hold for 3 cycles during LD_WAIT
        set_exe(5'd9, 1'b1, 2'b01);
        set_id(5'd9, 1'b1, 5'd0, 1'b0);
        settle();
        check_outs("hd.c0", 1, 1, 0, 1, 0);
        tick();
        exe_bubble();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            br_taken = (i == 1);
            settle();
            check_outs("hd.frz", 1, 0, 0, 1, 0);
            check("hd.frz.state", 32'(dbg_state), 32'(S_LD_WAIT));
            check("hd.frz.cnt", stall_cnt, 32'd3);
            tick();
        end
        hold = 1'b0;
        br_taken = 1'b0;
        settle();
        check_outs("hd.rel", 0, 0, 0, 0, 1);
        check("hd.rel.state", 32'(dbg_state), 32'(S_LD_WAIT));
        tick();
        settle();
        check_outs("hd.after", 0, 0, 0, 0, 0);
        check("hd.after.state", 32'(dbg_state), 32'(S_LD_FWD));
        check("hd.cnt", stall_cnt, 32'd3);
        tick();

        // Reset asserted in a RUN&hz cycle
        set_exe(5'd3, 1'b1, 2'b01);
        set_id(5'd3, 1'b1, 5'd0, 1'b0);
        settle();
        check_outs("ra.pre", 1, 1, 0, 1, 0);
        reset = 1'b0;
        #1;
        check_outs("ra.in", 0, 0, 0, 0, 0);
        check("ra.in.cnt", stall_cnt, 32'd0);
        tick();
        exe_bubble();
        set_id(5'd0, 1'b0, 5'd0, 1'b0);
        reset = 1'b1;
        settle();
        check("ra.rel.state", 32'(dbg_state), 32'(S_RUN));
        check_outs("ra.rel", 0, 0, 0, 0, 0);
        tick();
        settle();
        check("ra.rel2.id_lw", 32'(id_lw), 32'd0);
        check("ra.rel2.cnt", stall_cnt, 32'd0);
        check("ra.rel2.cnt4", 32'(stall_cnt4), 32'd0);

        // Saturation: constant hazard stalls every other cycle
        set_exe(5'd1, 1'b1, 2'b01);
        set_id(5'd1, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (i == 2) begin
                settle();
                check("sat.fwd.state", 32'(dbg_state), 32'(S_LD_FWD));
                check("sat.fwd.keep", 32'(keep), 32'd1);
            end
            tick();
        end
        settle();
        check("sat.cnt4", 32'(stall_cnt4), 32'hF);
        check("sat.cnt32", stall_cnt, 32'd20);
        for (int i = 0; i < 10; i++) tick();
        settle();
        check("sat.cnt4.hold", 32'(stall_cnt4), 32'hF);
        check("sat.cnt32.more", stall_cnt, 32'd25);
        check("sat4.keep", 32'(keep4), 32'd1);
        check("sat4.bubble", 32'(bubble_ex4), 32'd1);
        check("sat4.flush", 32'(flush_ifid4), 32'd0);
        check("sat4.lw_exe", 32'(id_lw_exe4), 32'd1);
        check("sat4.lw", 32'(id_lw4), 32'd0);
        check("sat4.state", 32'(dbg_state4), 32'(S_LD_FWD));

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_load_use_hazard_ctrl
